data_axi_bridge: RTL and testbench
==================================

Name: data_axi_bridge

Overview:
- Sits directly downstream of the CPU core's data port (data_sram_en/wen/addr/wdata/rdata).
- Converts each single-word data request into an AXI4 transaction: read via AR/R, write via AW/W/B.
- Returns a stall to the core until the transaction finishes.
- One outstanding transaction at a time. Burst attributes (len 0, size 4 bytes, INCR) are tied off at top level and are not ports.

Parameters:
AXI_ID, 4'd1, value driven on arid and awid.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req_en  in  1  core data request valid (data_sram_en).
req_wen  in  4  byte write enables; 0 means read, nonzero means write.
req_addr  in  32  physical byte address, passed through unaltered.
req_wdata  in  32  store data.
stall  out  1  core must hold all req_* stable while high.
rdata  out  32  load data returned to core.
rdata_valid  out  1  one-cycle pulse, rdata valid.
err  out  1  one-cycle pulse, rresp/bresp was not OKAY.
arid  out  4  AR id.
araddr  out  32  AR address.
arvalid  out  1  AR valid.
arready  in  1  AR ready.
rdata_axi  in  32  R data.
rresp  in  2  R response.
rvalid  in  1  R valid.
rready  out  1  R ready.
awid  out  4  AW id.
awaddr  out  32  AW address.
awvalid  out  1  AW valid.
awready  in  1  AW ready.
wdata  out  32  W data.
wstrb  out  4  W strobes (= latched req_wen).
wvalid  out  1  W valid (wlast tied 1 at top).
wready  in  1  W ready.
bresp  in  2  B response.
bvalid  in  1  B valid.
bready  out  1  B ready.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All valid/ready outputs, rdata_valid, err, aw_done and w_done go to 0.
  - rdata, latched address/data/strobes go to 0.
  - stall reads 0 only while req_en is 0.
- States: IDLE, AR, R, WR, B, DONE.
- IDLE:
  - On req_en=1, latch addr, wdata and wen.
  - Next state is AR if wen==0, otherwise WR.
  - stall = req_en (combinational) in IDLE.
- AR: arvalid=1, araddr=latched addr. Go to R on arvalid&&arready. arvalid must not drop before the handshake.
- R: rready=1. On rvalid, capture rdata_axi into rdata, capture err_flag = (rresp!=0), go to DONE.
- WR:
  - awvalid = !aw_done, wvalid = !w_done.
  - aw_done sets on the AW handshake; w_done sets on the W handshake.
  - Either handshake may come first, or both in the same cycle.
  - Go to B when both have completed, counting a handshake completing in the current cycle. Both flags clear on leaving.
- B: bready=1. On bvalid, capture err_flag = (bresp!=0), go to DONE.
- DONE (exactly one cycle):
  - stall=0, so the core advances on this edge.
  - rdata_valid=1 for reads only; err=err_flag.
  - req_en is ignored in this cycle. Next state is IDLE.
- stall = 1 in AR, R, WR and B; 0 in DONE.
- Minimum latency with ready/valid responses arriving immediately:
  - Read: IDLE, AR, R, DONE. That is 3 stall cycles; release and rdata_valid on the 4th cycle.
  - Write: IDLE, WR, B, DONE. That is 3 stall cycles.
- Back-to-back requests: a new request is accepted in IDLE on the cycle after DONE. There is no bubble beyond that.
- Address and data are never modified. Unaligned addresses are the core's problem.
- A change of req_* while stall=1 is a protocol violation; the bridge uses the latched values.

Test Plan:
- Read, zero wait: req_en=1, wen=0, addr=0x1FC0_0010; arready=1; rvalid the cycle after AR with rdata_axi=0xDEADBEEF, rresp=0 -> stall high for 3 cycles, then rdata=0xDEADBEEF with a rdata_valid pulse, err=0.
- Write, AW before W: wen=4'b0011, addr=0x8000_0004, wdata=0x1234_5678; awready at cycle 1, wready held low until cycle 4 -> wvalid stays high until cycle 4; wstrb=0011; B entered only after W; stall released one cycle after bvalid.
- Write, W before AW and same-cycle case: both orders plus simultaneous ready -> each of AW and W handshakes exactly once, no duplicate valids, enters B correctly.
- Error response: read with rresp=2'b10 -> err pulses in DONE together with rdata_valid; next request proceeds normally.
- Back-to-back: read then write on consecutive core cycles -> second request accepted the cycle after DONE; no lost or duplicated transaction.
- Reset mid-transaction: assert reset while in R with rvalid low -> all valid/ready outputs drop immediately, state is IDLE; after release a new read completes normally.

Source files
------------

// File: rtl/data_axi_bridge.sv
// Core data-port to AXI4 bridge: one single-beat transaction at a time.
// The core is stalled until the read or write response returns.
module data_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_en,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata_axi,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_WR,
    S_B,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wen_q, wen_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_flag_q, err_flag_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        aw_now;
  logic        w_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wen_q      <= '0;
      rdata_q    <= '0;
      err_flag_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
      rdata_q    <= rdata_d;
      err_flag_q <= err_flag_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // A handshake in the current cycle counts as done for the WR exit test.
  assign aw_now = aw_done_q | awready;
  assign w_now  = w_done_q | wready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wen_d      = wen_q;
    rdata_d    = rdata_q;
    err_flag_d = err_flag_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_en) begin
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          wen_d      = req_wen;
          err_flag_d = 1'b0;
          state_d    = (req_wen == 4'd0) ? S_AR : S_WR;
        end
      end
      S_AR: begin
        if (arready) state_d = S_R;
      end
      S_R: begin
        if (rvalid) begin
          rdata_d    = rdata_axi;
          err_flag_d = (rresp != 2'b00);
          state_d    = S_DONE;
        end
      end
      S_WR: begin
        if (aw_now && w_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_B;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      S_B: begin
        if (bvalid) begin
          err_flag_d = (bresp != 2'b00);
          state_d    = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall       = 1'b1;
    arvalid     = 1'b0;
    rready      = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    rdata_valid = 1'b0;
    err         = 1'b0;
    unique case (state_q)
      S_IDLE: stall = req_en;
      S_AR:   arvalid = 1'b1;
      S_R:    rready = 1'b1;
      S_WR: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
      end
      S_B:    bready = 1'b1;
      S_DONE: begin
        stall       = 1'b0;
        rdata_valid = (wen_q == 4'd0);
        err         = err_flag_q;
      end
      default: stall = 1'b0;
    endcase
  end

  assign rdata  = rdata_q;
  assign arid   = AXI_ID;
  assign araddr = addr_q;
  assign awid   = AXI_ID;
  assign awaddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wen_q;

endmodule

// File: tb/tb_data_axi_bridge.sv
// Scoreboard bench for data_axi_bridge with a latency-programmable
// AXI slave; stimulus and checking run in separate processes.
module tb_data_axi_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_en = 1'b0;
  logic [3:0]  req_wen = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata_axi = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;

  always #5 clk = ~clk;

  data_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk(clk), .reset(reset),
    .req_en(req_en), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .err(err),
    .arid(arid), .araddr(araddr),
    .arvalid(arvalid), .arready(arready),
    .rdata_axi(rdata_axi), .rresp(rresp),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb),
    .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wen;
    bit          err;
    int          stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  int ar_lat, r_lat, aw_lat, w_lat, b_lat;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;

  int ar_tot = 0, aw_tot = 0, w_tot = 0;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb, cap_arid, cap_awid;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // AXI slave: drives on negedge, sees handshakes at the prior negedge.
  bit ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, b_pend;
  bit ar_wait, aw_wait, w_wait;
  int ar_c, aw_c, w_c, r_c, b_c, aw_open, w_open;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        {ar_hs, r_hs, aw_hs, w_hs, b_hs} = '0;
        {r_pend, b_pend, ar_wait, aw_wait, w_wait} = '0;
        {ar_c, aw_c, w_c, r_c, b_c} = '0;
        aw_open = 0;
        w_open = 0;
        {arready, awready, wready, rvalid, bvalid} = '0;
        continue;
      end
      if (ar_wait) chk("arvalid_hold", arvalid, 1);
      if (aw_wait) chk("awvalid_hold", awvalid, 1);
      if (w_wait)  chk("wvalid_hold", wvalid, 1);
      if (ar_hs) begin r_pend = 1; r_c = 0; end
      if (r_hs) r_pend = 0;
      if (aw_hs) aw_open++;
      if (w_hs) w_open++;
      if (b_hs) b_pend = 0;
      if (!b_pend && aw_open > 0 && w_open > 0) begin
        b_pend = 1;
        b_c = 0;
        aw_open--;
        w_open--;
      end
      arready = arvalid && (ar_c >= ar_lat);
      ar_c = arvalid ? ar_c + 1 : 0;
      awready = awvalid && (aw_c >= aw_lat);
      aw_c = awvalid ? aw_c + 1 : 0;
      wready = wvalid && (w_c >= w_lat);
      w_c = wvalid ? w_c + 1 : 0;
      rvalid = r_pend && (r_c >= r_lat);
      if (r_pend) r_c++;
      bvalid = b_pend && (b_c >= b_lat);
      if (b_pend) b_c++;
      rdata_axi = rvalid ? s_rdata : 32'h0;
      rresp = s_rresp;
      bresp = s_bresp;
      ar_hs = arvalid && arready;
      r_hs = rvalid && rready;
      aw_hs = awvalid && awready;
      w_hs = wvalid && wready;
      b_hs = bvalid && bready;
      ar_wait = arvalid && !arready;
      aw_wait = awvalid && !awready;
      w_wait = wvalid && !wready;
      if (ar_hs) begin
        ar_tot++;
        cap_araddr = araddr;
        cap_arid = arid;
      end
      if (aw_hs) begin
        aw_tot++;
        cap_awaddr = awaddr;
        cap_awid = awid;
      end
      if (w_hs) begin
        w_tot++;
        cap_wdata = wdata;
        cap_wstrb = wstrb;
      end
    end
  end

  // Monitor: a completion is the cycle the core sees stall drop.
  int stall_c = 0;
  int last_ar = 0, last_aw = 0, last_w = 0;
  exp_t e;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_c = 0;
        last_ar = ar_tot;
        last_aw = aw_tot;
        last_w = w_tot;
        continue;
      end
      if ((rdata_valid || err) && !(req_en && !stall)) begin
        n_tests++;
        n_fail++;
        $display("FAIL stray_pulse: rdata_valid=%b err=%b",
                 rdata_valid, err);
      end
      if (req_en && stall) begin
        stall_c++;
      end else if (req_en && !stall) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          e = exp_q.pop_front();
          chk("stall_cycles", stall_c, e.stall);
          chk("rdata_valid", rdata_valid, !e.wr);
          chk("err", err, e.err);
          if (!e.wr) begin
            chk("rdata", rdata, e.data);
            chk("ar_count", ar_tot - last_ar, 1);
            chk("aw_count", aw_tot - last_aw, 0);
            chk("araddr", cap_araddr, e.addr);
            chk("arid", cap_arid, 1);
          end else begin
            chk("aw_count", aw_tot - last_aw, 1);
            chk("w_count", w_tot - last_w, 1);
            chk("ar_count", ar_tot - last_ar, 0);
            chk("awaddr", cap_awaddr, e.addr);
            chk("wdata", cap_wdata, e.data);
            chk("wstrb", cap_wstrb, e.wen);
            chk("awid", cap_awid, 1);
          end
        end
        stall_c = 0;
        last_ar = ar_tot;
        last_aw = aw_tot;
        last_w = w_tot;
      end
    end
  end

  task automatic set_lat(int a, int r, int aw, int w, int b);
    ar_lat = a;
    r_lat = r;
    aw_lat = aw;
    w_lat = w;
    b_lat = b;
  endtask

  // Called at posedge+1; returns at posedge+1 after the DONE edge.
  task automatic issue(bit wr, logic [31:0] addr,
                       logic [31:0] data, logic [3:0] wen,
                       logic [1:0] resp, bit exp_err, int exp_stall);
    exp_t x;
    int k;
    x.wr = wr;
    x.addr = addr;
    x.data = data;
    x.wen = wr ? wen : 4'd0;
    x.err = exp_err;
    x.stall = exp_stall;
    s_rdata = data;
    s_rresp = wr ? 2'b00 : resp;
    s_bresp = wr ? resp : 2'b00;
    exp_q.push_back(x);
    req_addr = addr;
    req_wdata = wr ? data : 32'h0;
    req_wen = x.wen;
    req_en = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!stall) break;
    end
    if (k == 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: stall still 1 expected 0");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_en = 1'b0;
    req_wen = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_lat(0, 0, 0, 0, 0);
    s_rdata = '0;
    s_rresp = '0;
    s_bresp = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_valids",
        {arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("rst_pulses", {rdata_valid, err}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_stall", stall, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    set_lat(0, 0, 0, 0, 0);
    issue(0, 32'h1FC0_0010, 32'hDEAD_BEEF, 4'h0, 2'b00, 0, 3);
    idle();
    set_lat(0, 0, 0, 3, 0);
    issue(1, 32'h8000_0004, 32'h1234_5678, 4'b0011, 2'b00, 0, 6);
    idle();
    set_lat(0, 0, 2, 0, 0);
    issue(1, 32'h8000_0100, 32'hA5A5_0F0F, 4'b1100, 2'b00, 0, 5);
    idle();
    set_lat(0, 0, 1, 1, 0);
    issue(1, 32'h0000_0008, 32'hCAFE_F00D, 4'b1111, 2'b00, 0, 4);
    idle();
    set_lat(0, 0, 0, 0, 2);
    issue(1, 32'h0000_0010, 32'h0000_00FF, 4'b0001, 2'b00, 0, 5);
    idle();
    set_lat(0, 0, 0, 0, 0);
    issue(0, 32'h1FC0_0014, 32'h0BAD_F00D, 4'h0, 2'b10, 1, 3);
    idle();
    set_lat(2, 1, 0, 0, 0);
    issue(0, 32'h1FC0_0020, 32'h1357_9BDF, 4'h0, 2'b00, 0, 6);
    idle();
    set_lat(0, 0, 0, 0, 1);
    issue(1, 32'h8000_0200, 32'h0F0F_F0F0, 4'b0110, 2'b11, 1, 4);
    idle();

    set_lat(0, 0, 0, 0, 0);
    issue(0, 32'h0000_0100, 32'h2468_ACE0, 4'h0, 2'b00, 0, 3);
    issue(1, 32'h0000_0104, 32'h1122_3344, 4'b1111, 2'b00, 0, 3);
    idle();

    set_lat(0, 20, 0, 0, 0);
    s_rdata = 32'h7777_7777;
    s_rresp = 2'b00;
    req_addr = 32'h1FC0_0030;
    req_wen = 4'h0;
    req_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rready", rready, 1);
    #2 reset = 1'b1;
    req_en = 1'b0;
    #1;
    chk("mid_rst_valids",
        {arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("mid_rst_pulses", {rdata_valid, err}, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_stall", stall, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    set_lat(0, 0, 0, 0, 0);
    issue(0, 32'h1FC0_0010, 32'h55AA_55AA, 4'h0, 2'b00, 0, 3);
    idle();

    for (int k = 0; k < 50 && exp_q.size() != 0; k++)
      @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
